// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares the buffer's parallel-write port between NUM_REQ producers.
// Each grant captures the winner's payload and drives one registered write pulse, then settles.
module fifo_write_arbiter #(
    parameter int unsigned NUM_BIT   = 4,
    parameter int unsigned PAR_WRITE = 2,
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned REQ_IDX   = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ*PAR_WRITE*NUM_BIT-1:0] req_data,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic [REQ_IDX-1:0]                   grant_id,
    input  logic                                 buf_ready,
    input  logic                                 buf_full,
    output logic                                 buf_write_en,
    output logic [PAR_WRITE*NUM_BIT-1:0]         buf_din,
    output logic                                 busy,
    output logic [7:0]                           wr_count
);

    localparam int unsigned W_WORD = PAR_WRITE * NUM_BIT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [REQ_IDX-1:0]   r_ptr;
    logic [REQ_IDX-1:0]   w_ptr;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [REQ_IDX-1:0]   r_gid;
    logic [REQ_IDX-1:0]   w_gid;
    logic                 r_wen;
    logic                 w_wen;
    logic [W_WORD-1:0]    r_din;
    logic [W_WORD-1:0]    w_din;
    logic                 r_busy;
    logic                 w_busy;
    logic [7:0]           r_cnt;
    logic [7:0]           w_cnt;
    logic [REQ_IDX-1:0]   w_winner;
    logic                 w_found;
    logic                 w_grant;

    // First asserted request searching upward from the slot after the last winner.
    always_comb begin
        logic [REQ_IDX-1:0] v_i;
        v_i      = '0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            v_i = REQ_IDX'((32'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req[v_i]) begin
                w_winner = v_i;
                w_found  = 1'b1;
            end
        end
    end

    assign w_grant = (r_state == IDLE) && w_found && buf_ready && !buf_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_next = WRITE;
            WRITE:   w_next = SETTLE;
            SETTLE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; the write pulse only exists on the grant edge.
    always_comb begin
        w_gnt  = '0;
        w_wen  = 1'b0;
        w_din  = r_din;
        w_gid  = r_gid;
        w_ptr  = r_ptr;
        w_cnt  = r_cnt;
        w_busy = (w_next != IDLE);
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_gnt = NUM_REQ'(1) << w_winner;
                    w_wen = 1'b1;
                    w_din = req_data[32'(w_winner) * W_WORD +: W_WORD];
                    w_gid = w_winner;
                    w_ptr = w_winner;
                end
            end
            WRITE: begin
                if (r_cnt != 8'hFF) w_cnt = r_cnt + 8'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt  <= '0;
            r_gid  <= REQ_IDX'(NUM_REQ - 1);
            r_ptr  <= REQ_IDX'(NUM_REQ - 1);
            r_wen  <= 1'b0;
            r_din  <= '0;
            r_busy <= 1'b0;
            r_cnt  <= 8'd0;
        end else begin
            r_gnt  <= w_gnt;
            r_gid  <= w_gid;
            r_ptr  <= w_ptr;
            r_wen  <= w_wen;
            r_din  <= w_din;
            r_busy <= w_busy;
            r_cnt  <= w_cnt;
        end
    end

    assign gnt          = r_gnt;
    assign grant_id     = r_gid;
    assign buf_write_en = r_wen;
    assign buf_din      = r_din;
    assign busy         = r_busy;
    assign wr_count     = r_cnt;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: cycle-by-cycle vector table plus reset-abort and saturation sequences.
module tb_fifo_write_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  gnt;
    logic        grant_id;
    logic        buf_ready;
    logic        buf_full;
    logic        buf_write_en;
    logic [7:0]  buf_din;
    logic        busy;
    logic [7:0]  wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_write_arbiter #(
        .NUM_BIT(4), .PAR_WRITE(2), .NUM_REQ(2), .REQ_IDX(1)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .grant_id(grant_id), .buf_ready(buf_ready), .buf_full(buf_full),
        .buf_write_en(buf_write_en), .buf_din(buf_din), .busy(busy), .wr_count(wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    typedef struct {
        logic        rst_b;
        logic [1:0]  req;
        logic [15:0] data;
        logic        ready;
        logic        full;
        logic [1:0]  gnt;
        logic        wen;
        logic [7:0]  din;
        logic        gid;
        logic        busy;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rb, input logic [1:0] rq, input logic [15:0] d,
                       input logic rdy, input logic fl, input logic [1:0] g, input logic we,
                       input logic [7:0] di, input logic gi, input logic bz, input logic [7:0] c);
        vec_t v;
        v.rst_b = rb; v.req = rq; v.data = d; v.ready = rdy; v.full = fl;
        v.gnt = g; v.wen = we; v.din = di; v.gid = gi; v.busy = bz; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req = 2'b00; req_data = 16'h0000; buf_ready = 1'b1; buf_full = 1'b0;

        // Single request from requester 0, dropped on grant.
        add(1, 2'b00, 16'h0000, 1, 0, 2'b00, 0, 8'h00, 1, 0, 8'd0);
        add(0, 2'b01, 16'h00B2, 1, 0, 2'b01, 1, 8'hB2, 0, 1, 8'd0);
        add(0, 2'b00, 16'h00B2, 1, 0, 2'b00, 0, 8'hB2, 0, 1, 8'd1);
        add(0, 2'b00, 16'h00B2, 1, 0, 2'b00, 0, 8'hB2, 0, 0, 8'd1);
        add(0, 2'b00, 16'h00B2, 1, 0, 2'b00, 0, 8'hB2, 0, 0, 8'd1);
        // Both requesters held: strict rotation 0,1,0,1 every third cycle.
        add(1, 2'b11, 16'hA51C, 1, 0, 2'b01, 1, 8'h1C, 0, 1, 8'd0);
        add(0, 2'b11, 16'hA51C, 1, 0, 2'b00, 0, 8'h1C, 0, 1, 8'd1);
        add(0, 2'b11, 16'hA51C, 1, 0, 2'b00, 0, 8'h1C, 0, 0, 8'd1);
        add(0, 2'b11, 16'hA51C, 1, 0, 2'b10, 1, 8'hA5, 1, 1, 8'd1);
        add(0, 2'b11, 16'hA51C, 1, 0, 2'b00, 0, 8'hA5, 1, 1, 8'd2);
        add(0, 2'b11, 16'hA51C, 1, 0, 2'b00, 0, 8'hA5, 1, 0, 8'd2);
        add(0, 2'b11, 16'hA51C, 1, 0, 2'b01, 1, 8'h1C, 0, 1, 8'd2);
        add(0, 2'b11, 16'hA51C, 1, 0, 2'b00, 0, 8'h1C, 0, 1, 8'd3);
        add(0, 2'b11, 16'hA51C, 1, 0, 2'b00, 0, 8'h1C, 0, 0, 8'd3);
        add(0, 2'b11, 16'hA51C, 1, 0, 2'b10, 1, 8'hA5, 1, 1, 8'd3);
        add(0, 2'b00, 16'hA51C, 1, 0, 2'b00, 0, 8'hA5, 1, 1, 8'd4);
        add(0, 2'b00, 16'hA51C, 1, 0, 2'b00, 0, 8'hA5, 1, 0, 8'd4);
        // Buffer full blocks requester 1 for 5 cycles, then it is served.
        for (int i = 0; i < 5; i++)
            add(0, 2'b10, 16'h7E00, 1, 1, 2'b00, 0, 8'hA5, 1, 0, 8'd4);
        add(0, 2'b10, 16'h7E00, 1, 0, 2'b10, 1, 8'h7E, 1, 1, 8'd4);
        add(0, 2'b00, 16'h7E00, 1, 0, 2'b00, 0, 8'h7E, 1, 1, 8'd5);
        add(0, 2'b00, 16'h7E00, 1, 0, 2'b00, 0, 8'h7E, 1, 0, 8'd5);
        // Buffer not ready blocks requester 0 until ready returns.
        for (int i = 0; i < 3; i++)
            add(0, 2'b01, 16'h0049, 0, 0, 2'b00, 0, 8'h7E, 1, 0, 8'd5);
        add(0, 2'b01, 16'h0049, 1, 0, 2'b01, 1, 8'h49, 0, 1, 8'd5);
        add(0, 2'b00, 16'h0049, 1, 0, 2'b00, 0, 8'h49, 0, 1, 8'd6);
        add(0, 2'b00, 16'h0049, 1, 0, 2'b00, 0, 8'h49, 0, 0, 8'd6);

        do_reset();
        check("reset gnt", 32'(gnt), 32'h0);
        check("reset grant_id", 32'(grant_id), 32'h1);
        check("reset wen", 32'(buf_write_en), 32'h0);
        check("reset din", 32'(buf_din), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset wr_count", 32'(wr_count), 32'h0);

        foreach (vecs[n]) begin
            if (vecs[n].rst_b) do_reset();
            req = vecs[n].req; req_data = vecs[n].data;
            buf_ready = vecs[n].ready; buf_full = vecs[n].full;
            step();
            check($sformatf("row%0d gnt", n), 32'(gnt), 32'(vecs[n].gnt));
            check($sformatf("row%0d wen", n), 32'(buf_write_en), 32'(vecs[n].wen));
            check($sformatf("row%0d din", n), 32'(buf_din), 32'(vecs[n].din));
            check($sformatf("row%0d grant_id", n), 32'(grant_id), 32'(vecs[n].gid));
            check($sformatf("row%0d busy", n), 32'(busy), 32'(vecs[n].busy));
            check($sformatf("row%0d wr_count", n), 32'(wr_count), 32'(vecs[n].cnt));
        end

        // Reset asserted mid-WRITE aborts the pulse without a clock edge.
        buf_ready = 1'b1; buf_full = 1'b0;
        do_reset();
        req = 2'b10; req_data = 16'hD400;
        step();
        check("abort pre wen", 32'(buf_write_en), 32'h1);
        check("abort pre gnt", 32'(gnt), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        check("abort wen", 32'(buf_write_en), 32'h0);
        check("abort gnt", 32'(gnt), 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        @(negedge clk);
        req = 2'b00;
        rst = 1'b0;
        #1;
        check("abort wr_count", 32'(wr_count), 32'h0);
        check("abort grant_id", 32'(grant_id), 32'h1);
        check("abort din", 32'(buf_din), 32'h0);
        step();
        check("abort idle wen", 32'(buf_write_en), 32'h0);

        // 300 back-to-back writes: the counter saturates at 255.
        do_reset();
        req = 2'b01; req_data = 16'h0011;
        for (int i = 1; i <= 300; i++) begin
            repeat (3) step();
            check($sformatf("sat write%0d wr_count", i), 32'(wr_count), (i > 255) ? 32'd255 : 32'(i));
        end
        req = 2'b00;
        repeat (6) step();
        check("sat hold wr_count", 32'(wr_count), 32'd255);
        check("sat hold busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
